// File: rtl/fifo_sync_fwft.sv
// Single-clock FIFO on a synchronous dual-port RAM with optional first-word-fall-through
// output register, occupancy count, almost-full/empty thresholds and drop pulses.
module fifo_sync_fwft #(
    parameter int unsigned DataWidth        = 32,
    parameter int unsigned Depth            = 16,
    parameter int unsigned Fwft             = 0,
    parameter int unsigned AlmostFullLevel  = Depth - 2,
    parameter int unsigned AlmostEmptyLevel = 1,
    localparam int unsigned PtrWidth        = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 writeEn,
    input  logic [DataWidth-1:0] writeData,
    output logic                 full,
    output logic                 almostFull,
    input  logic                 readEn,
    output logic [DataWidth-1:0] readData,
    output logic                 readValid,
    output logic                 empty,
    output logic                 almostEmpty,
    output logic [PtrWidth:0]    count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int unsigned CntWidth = PtrWidth + 1;
    localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
    localparam logic [CntWidth-1:0] AfLevel  = CntWidth'(AlmostFullLevel);
    localparam logic [CntWidth-1:0] AeLevel  = CntWidth'(AlmostEmptyLevel);

    logic [DataWidth-1:0] mem [Depth];

    logic [CntWidth-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic                 full_q, full_d, almost_full_q, almost_full_d;
    logic                 empty_q, empty_d, almost_empty_q, almost_empty_d;
    logic                 valid_q, valid_d, overflow_q, underflow_q;
    logic [DataWidth-1:0] data_q;
    logic                 wr_accept, rd_accept, ram_load, ram_nonempty;

    assign wr_accept    = writeEn && !full_q;
    assign ram_nonempty = wr_ptr_q != rd_ptr_q;

    // ram_load moves the RAM head into the output register and advances the read pointer.
    always_comb begin
        rd_accept = 1'b0;
        ram_load  = 1'b0;
        valid_d   = 1'b0;
        if (Fwft != 0) begin
            rd_accept = readEn && valid_q;
            ram_load  = ram_nonempty && (!valid_q || rd_accept);
            valid_d   = ram_load || (valid_q && !rd_accept);
        end else begin
            rd_accept = readEn && !empty_q;
            ram_load  = rd_accept;
            valid_d   = rd_accept;
        end
    end

    always_comb begin
        wr_ptr_d = wr_accept ? wr_ptr_q + CntOne : wr_ptr_q;
        rd_ptr_d = ram_load ? rd_ptr_q + CntOne : rd_ptr_q;
        count_d  = count_q;
        if (wr_accept && !rd_accept) begin
            count_d = count_q + CntOne;
        end else if (!wr_accept && rd_accept) begin
            count_d = count_q - CntOne;
        end
        full_d         = count_d == DepthCnt;
        almost_full_d  = count_d >= AfLevel;
        almost_empty_d = count_d <= AeLevel;
        empty_d        = (Fwft != 0) ? !valid_d : (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q[PtrWidth-1:0]] <= writeData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            almost_full_q  <= (AfLevel == '0);
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            valid_q        <= 1'b0;
            data_q         <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            valid_q        <= valid_d;
            overflow_q     <= writeEn && full_q;
            underflow_q    <= readEn && !rd_accept;
            if (ram_load) begin
                data_q <= mem[rd_ptr_q[PtrWidth-1:0]];
            end
        end
    end

    assign full        = full_q;
    assign almostFull  = almost_full_q;
    assign empty       = empty_q;
    assign almostEmpty = almost_empty_q;
    assign count       = count_q;
    assign readValid   = valid_q;
    assign readData    = data_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule
